// File: rtl/ads868x_pkg.sv
// ads868x_pkg
//   Shared constants for the ADS868x SPI responder: command opcodes, frame
//   length, command field positions, synchronizer lane indices and the FSM
//   state type. No ports; imported by the responder and its synchronizer.
package ads868x_pkg;

  localparam int FRAME_BITS = 32;

  localparam logic [6:0] OP_NOP        = 7'b0000000;
  localparam logic [6:0] OP_WRITE      = 7'b1101000;
  localparam logic [6:0] OP_READ_HWORD = 7'b1100100;

  // Command field positions inside the received 32-bit frame
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 25;
  localparam int ADDR_MSB   = 24;
  localparam int ADDR_LSB   = 16;
  localparam int WDATA_MSB  = 15;
  localparam int WDATA_LSB  = 0;

  // Lane order of the vectored pin synchronizer
  localparam int SYNC_SCK      = 0;
  localparam int SYNC_SS_N     = 1;
  localparam int SYNC_MOSI     = 2;
  localparam int SYNC_RST_PD_N = 3;
  localparam int SYNC_WIDTH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Halfword addresses above 9'h01F fall outside the emulated register file
  function automatic logic hword_in_range(input logic [8:0] addr);
    return (addr[8:5] == 4'd0);
  endfunction

endpackage

// File: rtl/ads868x_spi_sync.sv
// ads868x_spi_sync
//   Vectored multi-flop synchronizer for asynchronous SPI/control pins, plus one
//   extra flop per lane to produce single-cycle rise/fall pulses.
// Ports
//   aclk, aresetn     clock and asynchronous active-low reset
//   pins_in[W]        raw asynchronous pin levels
//   level[W]          synchronized level (last synchronizer stage)
//   rise[W], fall[W]  one-cycle edge pulses derived from the synchronized level
module ads868x_spi_sync
  import ads868x_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter int                    WIDTH       = SYNC_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VAL   = '0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;

  always_comb begin
    stage_d[0] = pins_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
    prev_d = stage_q[SYNC_STAGES-1];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage_q[s] <= RESET_VAL;
      end
      prev_q <= RESET_VAL;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign level = stage_q[SYNC_STAGES-1];
  assign rise  = stage_q[SYNC_STAGES-1] & ~prev_q;
  assign fall  = ~stage_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/ads868x_spi_responder.sv
// ads868x_spi_responder
//   Device-side emulation of an ADS868x SPI ADC, oversampling the SPI pins on
//   aclk. Returns {held sample, pending readback} each 32-bit frame, decodes
//   the received command, keeps a small halfword register file and pulls one
//   conversion result from an AXI4-Stream source at the end of every frame.
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready    conversion sample stream (tready = consume pulse)
//   SCK, SS_N, MOSI, MISO, MISO_T SPI mode 0 pins; MISO_T=1 means high-Z
//   RST_PD_N                      emulated device reset pin, active low
//   cmd_valid/opcode/addr/wdata   decoded command, valid for one cycle
//   frame_err                     pulse when a frame ends with a bad bit count
//   underrun_cnt                  saturating count of conversions without a sample
module ads868x_spi_responder
  import ads868x_pkg::*;
#(
  parameter int          NUM_HWORDS  = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] INIT_SAMPLE = 16'h8000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        SCK,
  input  logic        SS_N,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_T,
  input  logic        RST_PD_N,
  output logic        cmd_valid,
  output logic [6:0]  cmd_opcode,
  output logic [8:0]  cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        frame_err,
  output logic [15:0] underrun_cnt
);

  localparam logic [5:0] BIT_CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] BIT_CNT_MAX  = 6'(FRAME_BITS + 1);

  logic [SYNC_WIDTH-1:0] sync_level, sync_rise, sync_fall;

  // SS_N lane resets low so that releasing aresetn while SS_N is held low
  // does not look like a fresh frame start; a spurious rise in IDLE is harmless.
  ads868x_spi_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (SYNC_WIDTH),
    .RESET_VAL   (4'b1000)
  ) u_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .pins_in ({RST_PD_N, MOSI, SS_N, SCK}),
    .level   (sync_level),
    .rise    (sync_rise),
    .fall    (sync_fall)
  );

  logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_s, rst_pd_n_s;
  assign sck_rise   = sync_rise[SYNC_SCK];
  assign sck_fall   = sync_fall[SYNC_SCK];
  assign ss_rise    = sync_rise[SYNC_SS_N];
  assign ss_fall    = sync_fall[SYNC_SS_N];
  assign mosi_s     = sync_level[SYNC_MOSI];
  assign rst_pd_n_s = sync_level[SYNC_RST_PD_N];

  logic unused_sync;
  assign unused_sync = ^{sync_level[SYNC_SCK], sync_level[SYNC_SS_N],
                         sync_rise[SYNC_MOSI], sync_rise[SYNC_RST_PD_N],
                         sync_fall[SYNC_MOSI], sync_fall[SYNC_RST_PD_N]};

  state_e      state_q, state_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic [31:0] rx_sr_q, rx_sr_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        miso_q, miso_d;
  logic        miso_t_q, miso_t_d;
  logic        start_pend_q, start_pend_d;
  logic [15:0] held_q, held_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] underrun_q, underrun_d;
  logic [15:0] regs_q [NUM_HWORDS];
  logic [15:0] regs_d [NUM_HWORDS];

  logic [6:0]  rx_opcode;
  logic [8:0]  rx_addr;
  logic [15:0] rx_wdata;
  logic [3:0]  reg_idx;
  logic        addr_ok;

  assign rx_opcode = rx_sr_q[OPCODE_MSB:OPCODE_LSB];
  assign rx_addr   = rx_sr_q[ADDR_MSB:ADDR_LSB];
  assign rx_wdata  = rx_sr_q[WDATA_MSB:WDATA_LSB];
  assign reg_idx   = rx_addr[4:1];
  assign addr_ok   = hword_in_range(rx_addr) && (32'(reg_idx) < NUM_HWORDS);

  // Frame FSM, command execution and end-of-frame conversion. The emulated
  // reset pin overrides everything except the held sample and underrun count.
  // A frame aborted this way produces neither cmd_valid nor frame_err.
  always_comb begin
    state_d       = state_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    bit_cnt_d     = bit_cnt_q;
    miso_d        = miso_q;
    miso_t_d      = miso_t_q;
    start_pend_d  = start_pend_q;
    held_d        = held_q;
    pending_d     = pending_q;
    underrun_d    = underrun_q;
    regs_d        = regs_q;
    cmd_valid     = 1'b0;
    frame_err     = 1'b0;
    s_axis_tready = 1'b0;

    if (!rst_pd_n_s) begin
      state_d      = ST_IDLE;
      miso_d       = 1'b0;
      miso_t_d     = 1'b1;
      start_pend_d = 1'b0;
      pending_d    = '0;
      for (int i = 0; i < NUM_HWORDS; i++) begin
        regs_d[i] = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          // start_pend_q catches an SS_N fall that landed in the DONE cycle
          if (ss_fall || start_pend_q) begin
            state_d      = ST_SHIFT;
            tx_sr_d      = {held_q, pending_q};
            miso_d       = held_q[15];
            miso_t_d     = 1'b0;
            bit_cnt_d    = '0;
            start_pend_d = 1'b0;
          end
        end

        ST_SHIFT: begin
          if (ss_rise) begin
            state_d  = ST_DONE;
            miso_d   = 1'b0;
            miso_t_d = 1'b1;
          end else begin
            if (sck_rise) begin
              rx_sr_d = {rx_sr_q[30:0], mosi_s};
              if (bit_cnt_q != BIT_CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
              end
            end
            // Zero fill means MISO idles low once all 32 bits have gone out
            if (sck_fall) begin
              tx_sr_d = {tx_sr_q[30:0], 1'b0};
              miso_d  = tx_sr_q[30];
            end
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
          if (ss_fall) begin
            start_pend_d = 1'b1;
          end

          if (bit_cnt_q == BIT_CNT_FULL) begin
            cmd_valid = 1'b1;
            case (rx_opcode)
              OP_WRITE: begin
                pending_d = '0;
                if (addr_ok && !rx_addr[0]) begin
                  regs_d[reg_idx] = rx_wdata;
                end
              end
              OP_READ_HWORD: begin
                pending_d = addr_ok ? regs_q[reg_idx] : 16'h0000;
              end
              default: begin
                pending_d = '0;
              end
            endcase
          end else begin
            frame_err = 1'b1;
            pending_d = '0;
          end

          // Every finished frame, good or not, kicks off one conversion
          if (s_axis_tvalid) begin
            s_axis_tready = 1'b1;
            held_d        = s_axis_tdata;
          end else if (underrun_q != 16'hFFFF) begin
            underrun_d = underrun_q + 16'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      bit_cnt_q    <= '0;
      miso_q       <= 1'b0;
      miso_t_q     <= 1'b1;
      start_pend_q <= 1'b0;
      held_q       <= INIT_SAMPLE;
      pending_q    <= '0;
      underrun_q   <= '0;
      for (int i = 0; i < NUM_HWORDS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      miso_q       <= miso_d;
      miso_t_q     <= miso_t_d;
      start_pend_q <= start_pend_d;
      held_q       <= held_d;
      pending_q    <= pending_d;
      underrun_q   <= underrun_d;
      regs_q       <= regs_d;
    end
  end

  assign MISO         = miso_q;
  assign MISO_T       = miso_t_q;
  assign cmd_opcode   = rx_opcode;
  assign cmd_addr     = rx_addr;
  assign cmd_wdata    = rx_wdata;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_ads868x_spi_responder.sv
// tb_ads868x_spi_responder
//   Acts as the SPI master and sample source for the responder. A table of
//   frames drives the main traffic; hand-written sequences cover the emulated
//   reset pin and an aresetn pulse in the middle of a frame. Expected command
//   events are queued per frame and matched by a monitor as the DUT pulses.
module tb_ads868x_spi_responder;
  import ads868x_pkg::*;

  localparam time HALF = 50ns;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        SCK, SS_N, MOSI, MISO, MISO_T, RST_PD_N;
  logic        cmd_valid;
  logic [6:0]  cmd_opcode;
  logic [8:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        frame_err;
  logic [15:0] underrun_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int tready_cnt = 0;
  int ev_cnt     = 0;
  int tready_start;

  typedef struct {
    logic [31:0] mosi;
    int          nbits;
    logic        tvalid;
    logic [15:0] tdata;
    logic [31:0] exp_miso;
    int          exp_ev;
    logic [15:0] exp_under;
  } vec_t;

  typedef struct {
    bit          is_err;
    logic [6:0]  op;
    logic [8:0]  addr;
    logic [15:0] wdata;
  } ev_t;

  ev_t  ev_q[$];
  vec_t vecs[10];

  ads868x_spi_responder dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .SCK           (SCK),
    .SS_N          (SS_N),
    .MOSI          (MOSI),
    .MISO          (MISO),
    .MISO_T        (MISO_T),
    .RST_PD_N      (RST_PD_N),
    .cmd_valid     (cmd_valid),
    .cmd_opcode    (cmd_opcode),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .frame_err     (frame_err),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cmd_valid/frame_err pulse must match the oldest queued event
  always @(negedge aclk) begin
    if (s_axis_tready) tready_cnt++;
    if (cmd_valid || frame_err) begin
      ev_cnt++;
      if (ev_q.size() == 0) begin
        check("unexpected_event", 32'({cmd_valid, frame_err}), 32'd0);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        check("ev_frame_err", 32'(frame_err), 32'(e.is_err));
        check("ev_cmd_valid", 32'(cmd_valid), 32'(!e.is_err));
        if (!e.is_err) begin
          check("ev_opcode", 32'(cmd_opcode), 32'(e.op));
          check("ev_addr",   32'(cmd_addr),   32'(e.addr));
          check("ev_wdata",  32'(cmd_wdata),  32'(e.wdata));
        end
      end
    end
  end

  // Clocks n bits of a command word out MSB first, capturing MISO before each rise
  task automatic shiftBits(input logic [31:0] mosi, input int n, inout logic [31:0] cap);
    for (int i = 0; i < n; i++) begin
      MOSI = mosi[31-i];
      #HALF;
      cap = {cap[30:0], MISO};
      SCK = 1'b1;
      #HALF;
      SCK = 1'b0;
    end
    MOSI = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] mosi, input int nbits, input logic tv,
                               input logic [15:0] td, input int exp_ev, output logic [31:0] cap);
    ev_t e;
    cap = '0;
    tready_start  = tready_cnt;
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    if (exp_ev != 0) begin
      e.is_err = (exp_ev == 2);
      e.op     = mosi[31:25];
      e.addr   = mosi[24:16];
      e.wdata  = mosi[15:0];
      ev_q.push_back(e);
    end
    SS_N = 1'b0;
    #HALF;
    check("miso_t_active", 32'(MISO_T), 32'd0);
    shiftBits(mosi, nbits, cap);
    #HALF;
    SS_N = 1'b1;
    repeat (40) #10ns;
    check("event_timeout", 32'(ev_q.size()), 32'd0);
    s_axis_tvalid = 1'b0;
    #HALF;
  endtask

  task automatic checkOutput(input int idx, input logic [31:0] cap, input int nbits,
                             input logic [31:0] exp_miso, input logic [15:0] exp_under,
                             input logic tv);
    check($sformatf("f%0d_miso_word", idx), cap, exp_miso >> (32 - nbits));
    check($sformatf("f%0d_underrun", idx), 32'(underrun_cnt), 32'(exp_under));
    check($sformatf("f%0d_tready_pulses", idx), 32'(tready_cnt - tready_start), tv ? 32'd1 : 32'd0);
    check($sformatf("f%0d_miso_t_idle", idx), 32'(MISO_T), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] cap;
    int          ev_before;

    vecs[0] = '{32'h0000_0000, 32, 1'b0, 16'h0000, 32'h8000_0000, 1, 16'd1};
    vecs[1] = '{32'hD004_A5C3, 32, 1'b1, 16'h1234, 32'h8000_0000, 1, 16'd1};
    vecs[2] = '{32'hC804_0000, 32, 1'b1, 16'h5678, 32'h1234_0000, 1, 16'd1};
    vecs[3] = '{32'h0000_0000, 32, 1'b0, 16'h0000, 32'h5678_A5C3, 1, 16'd2};
    vecs[4] = '{32'hD004_0000, 20, 1'b1, 16'h9ABC, 32'h5678_0000, 2, 16'd2};
    vecs[5] = '{32'hD040_1111, 32, 1'b0, 16'h0000, 32'h9ABC_0000, 1, 16'd3};
    vecs[6] = '{32'hD005_2222, 32, 1'b0, 16'h0000, 32'h9ABC_0000, 1, 16'd4};
    vecs[7] = '{32'hC840_0000, 32, 1'b0, 16'h0000, 32'h9ABC_0000, 1, 16'd5};
    vecs[8] = '{32'hC804_0000, 32, 1'b0, 16'h0000, 32'h9ABC_0000, 1, 16'd6};
    vecs[9] = '{32'h0000_0000, 32, 1'b0, 16'h0000, 32'h9ABC_A5C3, 1, 16'd7};

    aresetn       = 1'b0;
    SCK           = 1'b0;
    SS_N          = 1'b1;
    MOSI          = 1'b0;
    RST_PD_N      = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;

    // Inputs change 2ns after a rising aclk edge throughout the run
    @(posedge aclk);
    #2ns;
    repeat (4) #10ns;
    check("rst_miso",     32'(MISO),          32'd0);
    check("rst_miso_t",   32'(MISO_T),        32'd1);
    check("rst_tready",   32'(s_axis_tready), 32'd0);
    check("rst_cmd",      32'(cmd_valid),     32'd0);
    check("rst_ferr",     32'(frame_err),     32'd0);
    check("rst_underrun", 32'(underrun_cnt),  32'd0);
    aresetn = 1'b1;
    repeat (10) #10ns;

    $display("[TB] table-driven frames");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].mosi, vecs[i].nbits, vecs[i].tvalid, vecs[i].tdata,
                    vecs[i].exp_ev, cap);
      checkOutput(i, cap, vecs[i].nbits, vecs[i].exp_miso, vecs[i].exp_under, vecs[i].tvalid);
    end

    $display("[TB] RST_PD_N mid-frame");
    applyStimulus(32'hD004_5A5A, 32, 1'b0, 16'h0000, 1, cap);
    checkOutput(10, cap, 32, 32'h9ABC_0000, 16'd8, 1'b0);
    ev_before    = ev_cnt;
    tready_start = tready_cnt;
    cap          = '0;
    SS_N = 1'b0;
    #HALF;
    shiftBits(32'hC804_0000, 10, cap);
    RST_PD_N = 1'b0;
    #30ns;
    check("rstpd_miso_t", 32'(MISO_T), 32'd1);
    #100ns;
    SS_N = 1'b1;
    #100ns;
    RST_PD_N = 1'b1;
    #400ns;
    check("rstpd_no_event",  32'(ev_cnt), 32'(ev_before));
    check("rstpd_no_tready", 32'(tready_cnt - tready_start), 32'd0);
    check("rstpd_underrun",  32'(underrun_cnt), 32'd8);
    applyStimulus(32'hC804_0000, 32, 1'b0, 16'h0000, 1, cap);
    checkOutput(11, cap, 32, 32'h9ABC_0000, 16'd9, 1'b0);
    applyStimulus(32'h0000_0000, 32, 1'b0, 16'h0000, 1, cap);
    checkOutput(12, cap, 32, 32'h9ABC_0000, 16'd10, 1'b0);

    $display("[TB] aresetn mid-frame");
    ev_before = ev_cnt;
    cap       = '0;
    SS_N = 1'b0;
    #HALF;
    shiftBits(32'hD004_FFFF, 5, cap);
    aresetn = 1'b0;
    #20ns;
    check("areset_miso_t",   32'(MISO_T),       32'd1);
    check("areset_miso",     32'(MISO),         32'd0);
    check("areset_underrun", 32'(underrun_cnt), 32'd0);
    aresetn = 1'b1;
    repeat (5) #10ns;
    check("areset_stays_hiz", 32'(MISO_T), 32'd1);
    shiftBits(32'hFFFF_FFFF, 10, cap);
    #HALF;
    SS_N = 1'b1;
    repeat (40) #10ns;
    check("areset_no_event", 32'(ev_cnt), 32'(ev_before));
    applyStimulus(32'h0000_0000, 32, 1'b0, 16'h0000, 1, cap);
    checkOutput(13, cap, 32, 32'h8000_0000, 16'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
